deser_flex: RTL and testbench

DESER_FLEX -- requirements
Module: deser_flex

---
 rtl/deser_flex_pkg.sv | 14 +
 rtl/deser_flex_out_reg.sv | 40 ++++
 rtl/deser_flex.sv | 102 ++++++++++
 tb/tb_deser_flex.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/deser_flex_pkg.sv
// Shared types and helpers for the flexible-width deserialiser.
package deser_flex_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_t;

  // A zero or out-of-range length means "a full word".
  function automatic int eff_len(input int len, input int beats);
    return (len == 0 || len > beats) ? beats : len;
  endfunction

endpackage

// File: rtl/deser_flex_out_reg.sv
// Valid/ready output register. A completion that arrives while a word is
// still held is dropped and flagged with a one-cycle overflow pulse.
module deser_flex_out_reg #(
  parameter int DATA_W = 16,
  parameter int LEN_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic [LEN_W-1:0]  load_beats,
  input  logic              ready,
  output logic [DATA_W-1:0] data,
  output logic [LEN_W-1:0]  beats,
  output logic              valid,
  output logic              overflow
);

  logic free;
  assign free = !valid || ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data     <= '0;
      beats    <= '0;
      valid    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      overflow <= load && !free;
      if (load && free) begin
        data  <= load_data;
        beats <= load_beats;
        valid <= 1'b1;
      end else if (ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/deser_flex.sv
// Deserialiser: packs LANES-bit beats into DATA_W-bit words of run-time
// selectable length, MSB- or LSB-first, with flush of partial words.
module deser_flex
  import deser_flex_pkg::*;
#(
  parameter  int DATA_W = 16,
  parameter  int LANES  = 1,
  localparam int BEATS  = DATA_W / LANES,
  localparam int LEN_W  = $clog2(BEATS + 1)
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic [LANES-1:0]  data_i,
  input  logic              data_val_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic              msb_first_i,
  input  logic              flush_i,
  output logic [DATA_W-1:0] deser_data_o,
  output logic [LEN_W-1:0]  deser_beats_o,
  output logic              deser_data_val_o,
  input  logic              deser_data_ready_i,
  output logic              overflow_o
);

  if (DATA_W % LANES != 0) begin : g_bad_cfg
    $error("deser_flex: DATA_W must be a multiple of LANES");
  end

  state_t            state;
  logic [LEN_W-1:0]  cnt;
  logic [LEN_W-1:0]  len_q;
  logic              msb_q;
  logic [DATA_W-1:0] acc;

  logic [LEN_W-1:0]  eff;
  logic [LEN_W-1:0]  word_len;
  logic              word_msb;
  logic [LEN_W-1:0]  cnt_nxt;
  logic [DATA_W-1:0] acc_nxt;
  logic              cmpl;
  logic [DATA_W-1:0] cmpl_data;
  logic [LEN_W-1:0]  cmpl_beats;

  // Length and mode are latched on the first beat; acc and cnt are zero in IDLE.
  always_comb begin
    eff      = LEN_W'(eff_len(int'(len_i), BEATS));
    word_len = (state == IDLE) ? eff : len_q;
    word_msb = (state == IDLE) ? msb_first_i : msb_q;
    cnt_nxt  = cnt + 1'b1;
    if (word_msb) acc_nxt = (acc << LANES) | DATA_W'(data_i);
    else          acc_nxt = acc | (DATA_W'(data_i) << (LANES * int'(cnt)));
    cmpl       = 1'b0;
    cmpl_data  = acc;
    cmpl_beats = cnt;
    if (data_val_i) begin
      cmpl       = (cnt_nxt == word_len) || flush_i;
      cmpl_data  = acc_nxt;
      cmpl_beats = cnt_nxt;
    end else if (flush_i && state == ACC) begin
      cmpl = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state <= IDLE;
      cnt   <= '0;
      acc   <= '0;
      len_q <= '0;
      msb_q <= 1'b0;
    end else if (cmpl) begin
      state <= IDLE;
      cnt   <= '0;
      acc   <= '0;
    end else if (data_val_i) begin
      state <= ACC;
      cnt   <= cnt_nxt;
      acc   <= acc_nxt;
      if (state == IDLE) begin
        len_q <= eff;
        msb_q <= msb_first_i;
      end
    end
  end

  deser_flex_out_reg #(
    .DATA_W (DATA_W),
    .LEN_W  (LEN_W)
  ) u_out_reg (
    .clk        (clk_i),
    .rst_n      (arst_n_i),
    .load       (cmpl),
    .load_data  (cmpl_data),
    .load_beats (cmpl_beats),
    .ready      (deser_data_ready_i),
    .data       (deser_data_o),
    .beats      (deser_beats_o),
    .valid      (deser_data_val_o),
    .overflow   (overflow_o)
  );

endmodule

// File: tb/tb_deser_flex.sv
// Bench for deser_flex: a 1-lane and a 4-lane instance checked every cycle
// against a word-level model, plus directed scenarios.
module tb_deser_flex;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance A: DATA_W=16, LANES=1 (LEN_W=5)
  logic       a_data, a_val, a_msb, a_flush, a_ready;
  logic [4:0] a_len;
  logic [15:0] a_dout;
  logic [4:0] a_beats;
  logic       a_dval, a_ovf;

  // Instance B: DATA_W=16, LANES=4 (LEN_W=3)
  logic [3:0] b_data;
  logic       b_val, b_msb, b_flush, b_ready;
  logic [2:0] b_len;
  logic [15:0] b_dout;
  logic [2:0] b_beats;
  logic       b_dval, b_ovf;

  deser_flex #(.DATA_W(16), .LANES(1)) u_a (
    .clk_i(clk), .arst_n_i(arst_n), .data_i(a_data), .data_val_i(a_val),
    .len_i(a_len), .msb_first_i(a_msb), .flush_i(a_flush),
    .deser_data_o(a_dout), .deser_beats_o(a_beats), .deser_data_val_o(a_dval),
    .deser_data_ready_i(a_ready), .overflow_o(a_ovf)
  );

  deser_flex #(.DATA_W(16), .LANES(4)) u_b (
    .clk_i(clk), .arst_n_i(arst_n), .data_i(b_data), .data_val_i(b_val),
    .len_i(b_len), .msb_first_i(b_msb), .flush_i(b_flush),
    .deser_data_o(b_dout), .deser_beats_o(b_beats), .deser_data_val_o(b_dval),
    .deser_data_ready_i(b_ready), .overflow_o(b_ovf)
  );

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  // Reference model state, index 0 = A, 1 = B
  int m_held[2];
  int m_eff[2];
  bit m_msb[2];
  int m_beat[2][16];
  bit e_val[2];
  int e_data[2];
  int e_beats[2];
  bit e_ovf[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_held[d] = 0; e_val[d] = 0; e_data[d] = 0; e_beats[d] = 0; e_ovf[d] = 0;
    end
  endtask

  // Word-level model: collect beats, build the word arithmetically on completion.
  task automatic model_step(input int d, input int lanes, input int beats,
                            input bit val, input int data, input int len,
                            input bit msb, input bit flush, input bit ready);
    bit cmpl;
    bit free;
    int n;
    int word;
    cmpl = 0; n = 0; word = 0;
    if (val) begin
      if (m_held[d] == 0) begin
        m_eff[d] = (len == 0 || len > beats) ? beats : len;
        m_msb[d] = msb;
      end
      m_beat[d][m_held[d]] = data;
      m_held[d]++;
      if (m_held[d] == m_eff[d] || flush) cmpl = 1;
    end else if (flush && m_held[d] > 0) begin
      cmpl = 1;
    end
    if (cmpl) begin
      n = m_held[d];
      for (int i = 0; i < n; i++) begin
        if (m_msb[d]) word = word * (1 << lanes) + m_beat[d][i];
        else          word = word + m_beat[d][i] * (1 << (i * lanes));
      end
      m_held[d] = 0;
    end
    free = !e_val[d] || ready;
    e_ovf[d] = cmpl && !free;
    if (cmpl && free) begin
      e_val[d] = 1; e_data[d] = word; e_beats[d] = n;
    end else if (ready) begin
      e_val[d] = 0;
    end
  endtask

  task automatic check_all();
    chk("a_valid", 32'(a_dval), 32'(e_val[0]));
    if (e_val[0]) begin
      chk("a_data", 32'(a_dout), e_data[0]);
      chk("a_beats", 32'(a_beats), e_beats[0]);
    end
    chk("a_overflow", 32'(a_ovf), 32'(e_ovf[0]));
    chk("b_valid", 32'(b_dval), 32'(e_val[1]));
    if (e_val[1]) begin
      chk("b_data", 32'(b_dout), e_data[1]);
      chk("b_beats", 32'(b_beats), e_beats[1]);
    end
    chk("b_overflow", 32'(b_ovf), 32'(e_ovf[1]));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step(0, 1, 16, a_val, int'(a_data), int'(a_len), a_msb, a_flush, a_ready);
    model_step(1, 4, 4, b_val, int'(b_data), int'(b_len), b_msb, b_flush, b_ready);
    #1;
    check_all();
  endtask

  // Asserted between edges; released on a falling edge so the next rising edge is live.
  task automatic apply_reset();
    @(negedge clk);
    arst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_a_data", 32'(a_dout), 0);
    chk("rst_a_beats", 32'(a_beats), 0);
    chk("rst_a_valid", 32'(a_dval), 0);
    chk("rst_a_overflow", 32'(a_ovf), 0);
    chk("rst_b_data", 32'(b_dout), 0);
    chk("rst_b_beats", 32'(b_beats), 0);
    chk("rst_b_valid", 32'(b_dval), 0);
    chk("rst_b_overflow", 32'(b_ovf), 0);
    @(posedge clk);
    @(negedge clk);
    arst_n = 1'b1;
  endtask

  initial begin
    logic [15:0] pat;
    int pulses;

    a_data = 0; a_val = 0; a_msb = 0; a_flush = 0; a_ready = 1; a_len = 0;
    b_data = 0; b_val = 0; b_msb = 0; b_flush = 0; b_ready = 1; b_len = 0;
    model_reset();
    apply_reset();

    // 1-lane full word, MSB-first
    pat = 16'b1010_0000_1111_0001;
    a_len = 0; a_msb = 1;
    for (int i = 0; i < 16; i++) begin
      a_val = 1; a_data = pat[15 - i];
      cycle();
    end
    chk("full_word_data", 32'(a_dout), 32'h0000A0F1);
    chk("full_word_beats", 32'(a_beats), 16);
    chk("full_word_valid", 32'(a_dval), 1);
    a_val = 0;
    cycle();
    chk("full_word_one_cycle", 32'(a_dval), 0);

    // 4-lane short word, LSB-first
    b_len = 2; b_msb = 0; b_val = 1; b_data = 4'h3;
    cycle();
    b_data = 4'hC;
    cycle();
    chk("lsb_short_data", 32'(b_dout), 32'h000000C3);
    chk("lsb_short_beats", 32'(b_beats), 2);

    // Flush with a beat, then a fresh word
    b_len = 4; b_msb = 1; b_data = 4'h1;
    cycle();
    b_data = 4'h2;
    cycle();
    b_data = 4'h3; b_flush = 1;
    cycle();
    b_flush = 0;
    chk("flush_data", 32'(b_dout), 32'h00000123);
    chk("flush_beats", 32'(b_beats), 3);
    for (int i = 4; i < 8; i++) begin
      b_data = 4'(i);
      cycle();
    end
    chk("after_flush_data", 32'(b_dout), 32'h00004567);
    chk("after_flush_beats", 32'(b_beats), 4);
    b_val = 0;
    cycle();

    // Overflow: downstream stalled across two completed words
    b_ready = 0; b_val = 1;
    for (int i = 0; i < 8; i++) begin
      b_data = (i < 4) ? 4'h1 : 4'h2;
      cycle();
      if (i == 3) chk("stall_first_word", 32'(b_dout), 32'h00001111);
    end
    chk("overflow_pulse", 32'(b_ovf), 1);
    b_val = 0;
    cycle();
    chk("overflow_single", 32'(b_ovf), 0);
    chk("held_word", 32'(b_dout), 32'h00001111);
    b_ready = 1;
    cycle();
    cycle();
    chk("dropped_not_emitted", 32'(b_dval), 0);

    // Continuous stream, then reset mid-word
    b_len = 4; b_msb = 1; b_val = 1; pulses = 0;
    for (int i = 0; i < 12; i++) begin
      b_data = 4'($urandom);
      cycle();
      if (b_dval) pulses++;
    end
    chk("stream_words", pulses, 3);
    b_data = 4'hE;
    cycle();
    b_data = 4'hF;
    cycle();
    apply_reset();
    b_data = 4'h8;
    cycle();
    chk("no_partial_after_reset", 32'(b_dval), 0);
    for (int i = 9; i < 12; i++) begin
      b_data = 4'(i);
      cycle();
    end
    chk("post_reset_data", 32'(b_dout), 32'h000089AB);
    chk("post_reset_beats", 32'(b_beats), 4);

    // Randomised traffic on both instances
    for (int c = 0; c < 500; c++) begin
      a_val   = ($urandom_range(0, 3) != 0);
      a_data  = 1'($urandom);
      a_len   = 5'($urandom_range(0, 31));
      a_msb   = 1'($urandom);
      a_flush = ($urandom_range(0, 11) == 0);
      a_ready = ($urandom_range(0, 3) != 0);
      b_val   = ($urandom_range(0, 3) != 0);
      b_data  = 4'($urandom);
      b_len   = 3'($urandom_range(0, 7));
      b_msb   = 1'($urandom);
      b_flush = ($urandom_range(0, 7) == 0);
      b_ready = ($urandom_range(0, 2) != 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
